// File: rtl/lidar_payload_streamer_pkg.sv
// Shared types and helpers for the LiDAR payload streamer.
package lidar_decoder_pkg;

  localparam int unsigned DEF_FRAME_W = 512;
  localparam int unsigned DEF_META_W  = 128;
  localparam int unsigned DEF_OUT_W   = 64;
  localparam int unsigned LIMIT       = DEF_FRAME_W - DEF_META_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ERR  = 2'd2
  } slicer_state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Saturating increment of a counter that is 'width' bits wide (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (count >= max_v) ? count : count + 32'd1;
  endfunction

endpackage

// File: rtl/lidar_payload_streamer_if.sv
// Frame input and payload beat output handshakes of the LiDAR payload streamer.
interface lidar_payload_streamer_if #(
  parameter int unsigned FRAME_W = 512,
  parameter int unsigned OUT_W   = 64,
  parameter int unsigned HDR_W   = $clog2(FRAME_W)
);
  logic                       in_valid;
  logic                       in_ready;
  logic [FRAME_W-1:0]         bitstream;
  logic [HDR_W-1:0]           header_length;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W-1:0]           out_data;
  logic [$clog2(OUT_W+1)-1:0] out_bits;
  logic                       out_last;

  modport master (
    output in_valid, bitstream, header_length, out_ready,
    input  in_ready, out_valid, out_data, out_bits, out_last
  );

  modport slave (
    input  in_valid, bitstream, header_length, out_ready,
    output in_ready, out_valid, out_data, out_bits, out_last
  );
endinterface

// File: rtl/lidar_payload_streamer_sat_counter.sv
// Saturating event counter used for frame statistics.
module lidar_sat_counter
  import lidar_decoder_pkg::*;
#(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  output logic [STAT_W-1:0] count_o
);

  logic [STAT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= STAT_W'(sat_inc(32'(count_q), STAT_W));
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lidar_payload_streamer.sv
// Strips header and trailing metadata from a raw frame and streams the payload LSB-first.
module lidar_payload_streamer
  import lidar_decoder_pkg::*;
#(
  parameter int unsigned FRAME_W = 512,
  parameter int unsigned META_W  = 128,
  parameter int unsigned OUT_W   = 64,
  parameter int unsigned HDR_W   = $clog2(FRAME_W),
  parameter int unsigned SIZE_W  = $clog2(FRAME_W+1),
  parameter int unsigned STAT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lidar_payload_streamer_if.slave s,
  output logic [SIZE_W-1:0]    data_size,
  output logic                 hdr_err,
  output logic [STAT_W-1:0]    frames_ok,
  output logic [STAT_W-1:0]    frames_err
);

  localparam int unsigned LIM    = FRAME_W - META_W;
  localparam int unsigned BITS_W = $clog2(OUT_W+1);

  slicer_state_t      state_q;
  logic [FRAME_W-1:0] buf_q;
  logic [SIZE_W-1:0]  rem_q;
  logic [SIZE_W-1:0]  size_q;
  logic               hdr_err_q;

  logic [SIZE_W-1:0]  hdr_ext;
  logic [SIZE_W-1:0]  size_d;
  logic               hdr_ok;
  logic               accept;
  logic               emit;
  logic               last_c;
  logic [FRAME_W-1:0] payload_d;

  always_comb begin
    hdr_ext   = SIZE_W'(s.header_length);
    hdr_ok    = (hdr_ext != '0) && (hdr_ext < SIZE_W'(LIM));
    size_d    = SIZE_W'(LIM) - hdr_ext;
    accept    = s.in_valid && (state_q == IDLE);
    emit      = (state_q == EMIT);
    last_c    = (rem_q <= SIZE_W'(OUT_W));
    // Keep only the payload bits so the final beat is zero above out_bits.
    payload_d = (s.bitstream >> s.header_length) & ~({FRAME_W{1'b1}} << size_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      rem_q     <= '0;
      size_q    <= '0;
      hdr_err_q <= 1'b0;
    end else begin
      hdr_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (hdr_ok) begin
              buf_q   <= payload_d;
              rem_q   <= size_d;
              size_q  <= size_d;
              state_q <= EMIT;
            end else begin
              size_q    <= '0;
              hdr_err_q <= 1'b1;
              state_q   <= ERR;
            end
          end
        end
        EMIT: begin
          if (s.out_ready) begin
            buf_q <= buf_q >> OUT_W;
            rem_q <= rem_q - SIZE_W'(OUT_W);
            if (last_c) state_q <= IDLE;
          end
        end
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s.in_ready  = (state_q == IDLE);
  assign s.out_valid = emit;
  assign s.out_data  = emit ? buf_q[OUT_W-1:0] : '0;
  assign s.out_bits  = !emit ? '0 : (last_c ? BITS_W'(rem_q) : BITS_W'(OUT_W));
  assign s.out_last  = emit && last_c;
  assign data_size   = size_q;
  assign hdr_err     = hdr_err_q;

  lidar_sat_counter #(.STAT_W(STAT_W)) u_ok_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (accept && hdr_ok),
    .count_o (frames_ok)
  );

  lidar_sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (accept && !hdr_ok),
    .count_o (frames_err)
  );

endmodule

// File: tb/tb_lidar_payload_streamer.sv
// Scoreboard bench for lidar_payload_streamer with a bit-level payload reference model.
module tb_lidar_payload_streamer;
  import lidar_decoder_pkg::*;

  localparam int FW  = 512;
  localparam int MW  = 128;
  localparam int OW  = 64;
  localparam int HW  = 9;
  localparam int SW  = 10;
  localparam int STW = 4;
  localparam int LIM = FW - MW;
  localparam int SAT = (1 << STW) - 1;

  typedef struct {
    logic [OW-1:0] data;
    int            bits;
    bit            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [SW-1:0]  data_size;
  logic           hdr_err;
  logic [STW-1:0] frames_ok;
  logic [STW-1:0] frames_err;

  bit force_ready;
  bit ready_val;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    n_ok  = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  lidar_payload_streamer_if #(.FRAME_W(FW), .OUT_W(OW), .HDR_W(HW)) bus ();

  lidar_payload_streamer #(
    .FRAME_W (FW),
    .META_W  (MW),
    .OUT_W   (OW),
    .HDR_W   (HW),
    .SIZE_W  (SW),
    .STAT_W  (STW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus),
    .data_size  (data_size),
    .hdr_err    (hdr_err),
    .frames_ok  (frames_ok),
    .frames_err (frames_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] r;
    for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int sat(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  always @(posedge clk) begin
    #2;
    bus.out_ready = force_ready ? ready_val : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on each beat handshake and checks stall stability.
  beat_t prev;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    if (rst || !bus.out_valid) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_data", bus.out_data, prev.data);
        chk("stall_bits", 64'(bus.out_bits), 64'(prev.bits));
        chk("stall_last", 64'(bus.out_last), 64'(prev.last));
      end
      prev.data = bus.out_data;
      prev.bits = int'(bus.out_bits);
      prev.last = bus.out_last;
      if (bus.out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat act=%0h exp=none", bus.out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", bus.out_data, e.data);
          chk("beat_bits", 64'(bus.out_bits), 64'(e.bits));
          chk("beat_last", 64'(bus.out_last), 64'(e.last));
        end
      end else begin
        stalled = 1'b1;
      end
    end
  end

  task automatic send(input logic [FW-1:0] bs, input int hdr);
    int  guard = 0;
    bit  ok;
    int  size;
    int  nb;
    while (bus.in_ready !== 1'b1) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        return;
      end
    end
    bus.in_valid      = 1'b1;
    bus.bitstream     = bs;
    bus.header_length = hdr[HW-1:0];
    ok   = (hdr > 0) && (hdr < LIM);
    size = ok ? LIM - hdr : 0;
    if (ok) begin
      n_ok++;
      nb = ceil_div(size, OW);
      for (int i = 0; i < nb; i++) begin
        beat_t b;
        b.data = '0;
        for (int j = 0; j < OW; j++) begin
          int k;
          k = i * OW + j;
          if (k < size) b.data[j] = bs[hdr + k];
        end
        b.bits = (size - i * OW < OW) ? size - i * OW : OW;
        b.last = (i == nb - 1);
        exp_q.push_back(b);
      end
    end else begin
      n_err++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
    chk("data_size", 64'(data_size), 64'(size));
    if (ok) begin
      chk("first_beat_latency", 64'(bus.out_valid), 64'd1);
    end else begin
      chk("hdr_err_pulse", 64'(hdr_err), 64'd1);
      chk("err_no_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      chk("hdr_err_clear", 64'(hdr_err), 64'd0);
      chk("in_ready_after_err", 64'(bus.in_ready), 64'd1);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(bus.in_ready === 1'b1 && exp_q.size() == 0)) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        chk("idle_timeout", 64'(exp_q.size()), 64'd0);
        return;
      end
    end
    chk("frames_ok", 64'(frames_ok), 64'(sat(n_ok)));
    chk("frames_err", 64'(frames_err), 64'(sat(n_err)));
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_bits", 64'(bus.out_bits), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_data_size", 64'(data_size), 64'd0);
    chk("rst_hdr_err", 64'(hdr_err), 64'd0);
    chk("rst_frames_ok", 64'(frames_ok), 64'd0);
    chk("rst_frames_err", 64'(frames_err), 64'd0);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.bitstream     = '0;
    bus.header_length = '0;
    force_ready       = 1'b1;
    ready_val         = 1'b1;
    rst               = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();

    send(rand_frame(), 128); wait_idle();
    send(rand_frame(), 100); wait_idle();
    send(rand_frame(), 0);   wait_idle();
    send(rand_frame(), 384); wait_idle();
    send(rand_frame(), 383); wait_idle();

    // Stall beat 2 for three clock edges.
    send(rand_frame(), 64);
    @(posedge clk); #1;
    ready_val = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    end
    ready_val = 1'b1;
    wait_idle();

    // Reset while beat 3 is on the output.
    send(rand_frame(), 64);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    n_ok  = 0;
    n_err = 0;
    check_reset_state();
    send(rand_frame(), 200); wait_idle();

    for (int i = 0; i < 18; i++) send(rand_frame(), 384 + i * 7);
    wait_idle();

    force_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int sel;
      int hdr;
      sel = $urandom_range(0, 9);
      if (sel == 0)      hdr = 0;
      else if (sel == 1) hdr = $urandom_range(LIM, FW - 1);
      else if (sel == 2) hdr = LIM - 1;
      else               hdr = $urandom_range(1, LIM - 1);
      send(rand_frame(), hdr);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
